// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: types and constants shared by the CPU input and output stream ports
package cpu_io_pkg;
  localparam int DATA_W = 64;
  typedef enum logic [1:0] {STREAM, CLOSED, DONE} port_state_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/io_fifo_mem.sv
// io_fifo_mem: register-array FIFO storage, synchronous write, asynchronous read
module io_fifo_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_input_port.sv
// cpu_input_port: host-to-CPU show-ahead word FIFO with end-of-stream tracking
module cpu_input_port
  import cpu_io_pkg::*;
#(
  parameter int DATA_W = cpu_io_pkg::DATA_W,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  output logic              host_ready,
  input  logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_eof,
  input  logic              rearm,
  output logic [ADDR_W:0]   count,
  output logic              underrun
);
  localparam int PW = ptr_w(DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic full, empty, accept, pop;
  port_state_t state, state_nx;
  io_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(accept),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(host_data),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(head)
  );
  assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign host_ready = !full && state == STREAM;
  assign cpu_valid = !empty;
  // storage is not reset, so mask the head word while nothing is buffered
  assign cpu_data = cpu_valid ? head : '0;
  assign cpu_eof = state == DONE;
  assign count = wr_ptr - rd_ptr;
  assign accept = host_valid && host_ready;
  assign pop = cpu_ready && cpu_valid;
  always_comb
    state_nx = state == STREAM ? (accept && host_last ? CLOSED : STREAM)
             : state == CLOSED ? (empty || (pop && count == (ADDR_W+1)'(1)) ? DONE : CLOSED)
             : (rearm ? STREAM : DONE);
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state <= STREAM;
      underrun <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (cpu_ready && !cpu_valid && state != DONE) underrun <= 1'b1;
      state <= state_nx;
    end
endmodule

// File: tb/tb_cpu_input_port.sv
// tb_cpu_input_port: vector table, directed corner sequences and random traffic against a queue model
module tb_cpu_input_port;
  localparam int DW = 64;
  localparam int DEPTH = 8;
  localparam int OW = DW + 8;
  typedef struct {
    bit hv, hl, cr, ra, rs;
    logic [DW-1:0] hd;
    logic [OW-1:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset, host_valid, host_last, cpu_ready, rearm;
  logic [DW-1:0] host_data, cpu_data;
  logic host_ready, cpu_valid, cpu_eof, underrun;
  logic [3:0] count;
  int checks = 0;
  int passes = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] popped[$];
  int mst = 0;
  bit mund = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  cpu_input_port dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_data(host_data), .host_last(host_last), .host_ready(host_ready),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_eof(cpu_eof),
    .rearm(rearm), .count(count), .underrun(underrun)
  );
  function automatic logic [OW-1:0] model_out();
    logic v;
    v = mq.size() != 0;
    return {v, mq.size() < DEPTH && mst == 0, mst == 2, mund, 4'(mq.size()), v ? mq[0] : {DW{1'b0}}};
  endfunction
  function automatic logic [OW-1:0] dut_out();
    return {cpu_valid, host_ready, cpu_eof, underrun, count, cpu_data};
  endfunction
  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (v,r,eof,und,cnt,data)", name, act, exp);
  endtask
  task automatic cycle(input bit hv, input logic [DW-1:0] hd, input bit hl, input bit cr, input bit ra, input bit rs);
    logic [OW-1:0] pre;
    bit acc, pp;
    host_valid = hv; host_data = hd; host_last = hl; cpu_ready = cr; rearm = ra; reset = rs;
    #1;
    pre = model_out();
    acc = hv && pre[OW-2];
    pp = cr && pre[OW-1];
    if (!rs && cpu_valid && cpu_ready) popped.push_back(cpu_data);
    @(posedge clk);
    if (rs) begin
      mq.delete(); mst = 0; mund = 0;
    end else begin
      if (cr && !pre[OW-1] && mst != 2) mund = 1;
      if (mst == 0 && acc && hl) mst = 1;
      else if (mst == 1 && (mq.size() == 0 || (pp && mq.size() == 1))) mst = 2;
      else if (mst == 2 && ra) mst = 0;
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(hd);
    end
    #1;
    check("model", dut_out(), model_out());
  endtask
  function automatic vec_t mk(input bit hv, input logic [DW-1:0] hd, input bit hl, input bit cr, input bit ra,
                              input bit rs, input bit v, input bit r, input bit e, input bit u,
                              input logic [3:0] c, input logic [DW-1:0] d);
    vec_t t;
    t.hv = hv; t.hd = hd; t.hl = hl; t.cr = cr; t.ra = ra; t.rs = rs;
    t.exp = {v, r, e, u, c, d};
    return t;
  endfunction
  initial begin
    logic [DW-1:0] w1, w2, wa, wb;
    int bad, maxc, n;
    w1 = 64'h1111111111111111; w2 = 64'h2222222222222222; wa = 64'hA; wb = 64'hB;
    //           hv data hl cr ra rs   v  r  e  u  cnt data
    tbl.push_back(mk(0, 0,  0, 0, 0, 1,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, w1, 0, 0, 0, 0,  1, 1, 0, 0, 1, w1));
    tbl.push_back(mk(1, w2, 0, 0, 0, 0,  1, 1, 0, 0, 2, w1));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,  1, 1, 0, 0, 1, w2));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, wa, 0, 0, 0, 0,  1, 1, 0, 0, 1, wa));
    tbl.push_back(mk(1, wb, 1, 0, 0, 0,  1, 0, 0, 0, 2, wa));
    tbl.push_back(mk(1, 64'hC, 0, 0, 0, 0, 1, 0, 0, 0, 2, wa));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,  1, 0, 0, 0, 1, wb));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0, 1, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,  0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0, 1, 0,  0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, w1, 1, 1, 0, 1,  0, 1, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].hv, tbl[i].hd, tbl[i].hl, tbl[i].cr, tbl[i].ra, tbl[i].rs);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0, 0, 0, 0);
    check("fill_full", OW'({host_ready, cpu_valid, count}), OW'({1'b0, 1'b1, 4'd8}));
    cycle(1, 64'd99, 0, 0, 0, 0);
    check("ninth_ignored", OW'({host_ready, count, cpu_data}), OW'({1'b0, 4'd8, 64'd0}));
    popped.delete();
    n = DEPTH;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
        cycle(1, DW'(n), 0, 0, 0, 0);
        n++;
      end
    end
    for (int k = 0; k < DEPTH + 1; k++) cycle(0, 0, 0, 1, 0, 0);
    check("wrap_total", OW'(popped.size()), OW'(n));
    bad = 0;
    foreach (popped[i]) if (popped[i] != DW'(i)) bad++;
    check("wrap_order", OW'(bad), OW'(0));
    popped.delete();
    maxc = 0;
    for (int i = 0; i <= 20; i++) begin
      cycle(1, DW'(i), 0, 1, 0, 0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    cycle(0, 0, 0, 1, 0, 0);
    check("stream_maxcount", OW'(maxc), OW'(1));
    check("stream_throughput", OW'(popped.size()), OW'(21));
    bad = 0;
    foreach (popped[i]) if (popped[i] != DW'(i)) bad++;
    check("stream_order", OW'(bad), OW'(0));
    for (int i = 0; i < 5; i++) cycle(1, DW'(100 + i), 0, 0, 0, 0);
    check("pre_reset", OW'({count, underrun, cpu_data}), OW'({4'd5, 1'b1, 64'd100}));
    cycle(1, 64'd7, 1, 1, 1, 1);
    check("mid_reset", dut_out(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 64'd0});
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 2) != 0, {$urandom, $urandom}, $urandom_range(0, 29) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cpu_input_port.md
Name: cpu_input_port

Overview:
- Input-side counterpart of the CPU's output_valid/output_data stream.
- Accepts 64-bit words from a host or testbench writer, buffers them in a small FIFO, and presents them to the CPU top entity as a show-ahead valid/ready read channel.
- Tracks end-of-stream so the CPU can detect that input is exhausted.
- Sits between the bench/host and the CPU, next to the output-stream monitor.

Parameters:
- DATA_W, 64, word width on both sides.
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH); pointers are ADDR_W+1 bits wide, with the extra bit used for wrap detection.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- host_valid  in  1  host offers host_data this cycle.
- host_data  in  DATA_W  word offered by host.
- host_last  in  1  qualifies host_data as the final word of the stream.
- host_ready  out  1  port can accept a host word this cycle.
- cpu_ready  in  1  CPU consumes cpu_data this cycle.
- cpu_valid  out  1  cpu_data holds a valid head-of-FIFO word.
- cpu_data  out  DATA_W  head-of-FIFO word (show-ahead).
- cpu_eof  out  1  stream closed and FIFO empty; no further data.
- rearm  in  1  one-cycle pulse; reopens the stream after DONE.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- underrun  out  1  sticky; CPU asserted cpu_ready while cpu_valid=0 and cpu_eof=0.

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - Pointers=0, count=0, state=STREAM.
  - cpu_valid=0, cpu_eof=0, underrun=0, host_ready=1, cpu_data=0.
  - Reset overrides every other input in the same cycle. Reset mid-stream discards buffered data and the latched last flag.
- Host accept: accept = host_valid & host_ready.
  - Word is written at wr_ptr on the clock edge; wr_ptr increments.
  - Word is visible on cpu_data/cpu_valid the following cycle. Latency is 1 cycle; there is no empty-bypass.
- CPU pop: pop = cpu_ready & cpu_valid.
  - rd_ptr increments; the next entry appears the following cycle.
  - cpu_data is driven from the registered head entry and is stable while cpu_valid=1 and no pop occurs.
- Full/empty:
  - full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) & (low bits equal).
  - empty = pointers equal.
  - host_ready = ~full & (state==STREAM). It does not depend on same-cycle cpu_ready; no write-through-when-full.
- Simultaneous accept and pop: count unchanged, both pointers advance.
- Wrap-around: pointers roll modulo 2*DEPTH; data order is preserved across the wrap.
- count = wr_ptr - rd_ptr, (ADDR_W+1)-bit modular subtraction; equals DEPTH when full.
- State machine:
  - STREAM: normal operation. An accept with host_last=1 moves to CLOSED (that word is stored).
  - CLOSED: host_ready=0; FIFO drains. When empty, or when the last pop leaves it empty, go to DONE on the next edge.
  - DONE: cpu_eof=1, cpu_valid=0, host_ready=0. rearm=1 goes to STREAM next cycle, with cpu_eof=0 from that cycle on.
  - rearm in STREAM or CLOSED is ignored.
- cpu_eof is registered: it asserts the cycle after the FIFO becomes empty in CLOSED.
- underrun: set on any cycle with cpu_ready=1, cpu_valid=0, state!=DONE. Cleared only by reset.
  - cpu_ready in DONE is harmless and does not set underrun.
- host_valid while host_ready=0: ignored; no state change, no flag.

Decomposition:
- Shared package cpu_io_pkg holds:
  - DATA_W constant (64), shared with the output-stream side.
  - Enum port_state_t {STREAM, CLOSED, DONE}.
  - Pointer-width helper function.
- One natural sub-module: io_fifo_mem, a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read at rd_ptr.
- State machine, pointers and flags stay in cpu_input_port.

Test Plan:
- Reset then idle 3 cycles -> cpu_valid=0, host_ready=1, count=0, cpu_eof=0, underrun=0.
- Write 0x1111111111111111, 0x2222222222222222 back-to-back, cpu_ready=0 -> cpu_valid=1 one cycle after first accept; cpu_data=0x1111...; count=2.
  - Then cpu_ready=1 for 2 cycles -> data 0x1111..., 0x2222... in order; count=0.
- Fill with 8 words 0x00..0x07, cpu_ready=0 -> host_ready=0 after 8th accept, count=8.
  - 9th host_valid is ignored.
  - Then pop 3 / push 3 repeatedly across 3 wraps -> output sequence strictly increasing, no loss or duplication.
- Continuous stream with host_valid=1 and cpu_ready=1 every cycle, words 0..20 -> count stays <=1, throughput 1 word/cycle after 1-cycle latency.
- Send 0xA, 0xB with host_last on 0xB, then pop both -> host_ready=0 after 0xB accept; cpu_eof=1 one cycle after second pop.
  - rearm pulse -> cpu_eof=0 and host_ready=1 next cycle.
- cpu_ready=1 on empty FIFO in STREAM -> underrun=1 and stays 1.
  - Assert reset mid-stream with count=5 -> all outputs return to reset values next cycle, including underrun=0.
